// File: rtl/inst_loader.sv
// Boot loader: framed byte stream -> big-endian words on the instruction memory write port, CPU held in reset until checksum passes.
// Latency: write pulse one cycle after a word's 4th byte; backpressure: in_ready low only during that write-pulse cycle.
module inst_loader #(
  parameter int          DEPTH      = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'd0,
  parameter logic [7:0]  START_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        inst_write_enable,
  output logic [31:0] inst_write_address,
  output logic [31:0] inst_data_in,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  bidx_q, bidx_d;
  logic [23:0] asm_q, asm_d;
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic accept;
  logic start;
  logic [15:0] len_full;

  assign in_ready = (state_q != S_WRITE);
  assign accept   = in_valid && in_ready;
  assign start    = accept && (in_data == START_BYTE) &&
                    (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign len_full = {len_q[15:8], in_data};

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    bidx_d    = bidx_q;
    asm_d     = asm_q;
    csum_d    = csum_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    error_d   = error_q;

    if (start) begin
      // A start marker in IDLE, DONE or ERR always begins a fresh load.
      state_d   = S_LEN_HI;
      csum_d    = 8'h00;
      addr_d    = BASE_ADDR;
      count_d   = 16'd0;
      bidx_d    = 2'd0;
      cpu_rst_d = 1'b1;
      done_d    = 1'b0;
      error_d   = 1'b0;
    end else begin
      case (state_q)
        S_LEN_HI: if (accept) begin
          len_d   = {in_data, 8'h00};
          state_d = S_LEN_LO;
        end
        S_LEN_LO: if (accept) begin
          len_d = len_full;
          if ({1'b0, len_full} > DEPTH_W) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: if (accept) begin
          asm_d  = {asm_q[15:0], in_data};
          csum_d = csum_q ^ in_data;
          bidx_d = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            data_d  = {asm_q, in_data};
            we_d    = 1'b1;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          // Pulse cycle: address advances and word count closes out afterwards.
          addr_d  = addr_q + 32'd1;
          count_d = count_q + 16'd1;
          state_d = ((count_q + 16'd1) == len_q) ? S_CSUM : S_DATA;
        end
        S_CSUM: if (accept) begin
          if (in_data == csum_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      len_q     <= 16'd0;
      count_q   <= 16'd0;
      bidx_q    <= 2'd0;
      asm_q     <= 24'd0;
      csum_q    <= 8'h00;
      we_q      <= 1'b0;
      addr_q    <= BASE_ADDR;
      data_q    <= 32'd0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      count_q   <= count_d;
      bidx_q    <= bidx_d;
      asm_q     <= asm_d;
      csum_q    <= csum_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign inst_write_enable  = we_q;
  assign inst_write_address = addr_q;
  assign inst_data_in       = data_q;
  assign cpu_rst            = cpu_rst_q;
  assign done               = done_q;
  assign error              = error_q;

endmodule
